mbist_counter: RTL and testbench
================================

Name: mbist_counter

Overview:
- March C- sequencer for the MBIST path. Sits directly downstream of the BIST controller.
- Consumes the controller's `ld` (load/idle) and `NbarT` (test-active) signals. Drives address, data and read/write strobes to the memory under test and to the response comparator.
- Raises `cout` on the final operation of the final march element, which returns the controller to its reset phase.

Parameters:
- ADDR_W, 4, address width; memory depth = 2**ADDR_W words.
- DATA_W, 8, data word width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock; synchronous, active-high.
- ld  input  1  load: return sequencer to start of march (controller reset phase).
- NbarT  input  1  test enable: advance one operation per cycle while high.
- addr  output  ADDR_W  memory address of current operation.
- wdata  output  DATA_W  write data.
- exp_data  output  DATA_W  expected read data for the comparator.
- we  output  1  write strobe.
- re  output  1  read strobe.
- elem  output  3  current march element index 0..5.
- cout  output  1  sequence-complete pulse.

Behaviour:
- March C- elements (direction; ops per address):
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 down (r0)
- Background values: "0" = all-zeros word, "1" = all-ones word.
- State registers: elem (0..5), addr, op index (0..1).
- Reset values: elem=0, addr=0, op=0. Outputs we=re=cout=0, wdata=exp_data=0.
- Priority: rst > ld > NbarT.
  - ld=1: state reloads to elem=0, addr=0, op=0. Strobes forced 0.
  - NbarT=0 and ld=0: state holds. Strobes 0.
- Outputs are combinational from registered state, gated by NbarT.
  - we/re are valid in the same cycle NbarT is high.
  - exp_data is valid whenever re=1. wdata is valid whenever we=1.
- Step rule (each clk with NbarT=1, ld=0):
  - If op is not the last op of the element: op++.
  - Otherwise op=0 and the address advances.
    - Up elements: addr++. Down elements: addr--.
  - On address terminal (up: all-ones; down: zero) with last op: elem++ and op=0.
    - Entering M0–M2: addr loads 0.
    - Entering M3–M5: addr loads all-ones.
- cout = NbarT & (elem==5) & (addr==0) & last op.
  - One cycle wide. On that edge the state wraps to elem=0, addr=0, op=0.
- Latency: total test cycles = 10 × 2**ADDR_W. cout is high in the final cycle.
- ld and NbarT both high: ld wins; no strobe issued.
- rst or ld mid-test: the sequence aborts immediately. There is no partial resume.
- Address arithmetic wraps modulo 2**ADDR_W. Terminal detection is explicit; wrap is never used to end an element.

Optional Feature:
- Macro MBIST_COUNTER_CHKBOARD_EN.
- Defined: background word per address is XORed with {DATA_W{addr[0]}}.
  - Applies to both wdata and exp_data.
  - Gives a checkerboard pattern; "0" at addr 1 is all-ones.
- Undefined: solid backgrounds only. Timing and cycle counts are identical either way.

Decomposition:
- Package mbist_pkg:
  - enum march_op_t {OP_W0, OP_W1, OP_R0, OP_R1}.
  - enum dir_t {DIR_UP, DIR_DOWN}.
  - constant NUM_ELEM=6.
  - constant function or table giving per-element direction, op count and op list.
- Sub-module mbist_addr_gen: up/down loadable address counter.
  - Inputs: clk, rst, load, load_val, en, dir.
  - Outputs: addr, at_terminal.

Test Plan:
- rst=1 for 2 cycles, then NbarT=0, ld=1 → addr=0, elem=0, we=re=cout=0; state static for 10 cycles.
- ADDR_W=2, NbarT=1 continuous → exactly 40 active cycles; cout=1 only in cycle 40.
  - Cycles 1–4: we=1, wdata=0x00, addr 0..3.
  - Cycle 5: re=1, exp_data=0x00, addr=0.
  - Cycle 6: we=1, wdata=0xFF, addr=0.
- Same run, elem boundary M2→M3 → addr sequence 3 then 3 (direction change reloads all-ones); elem 2→3.
- NbarT dropped for 3 cycles mid-M1 → state and addr frozen, strobes 0; the sequence resumes with the same operation when NbarT returns.
- ld=1 pulse at cycle 17 with NbarT=1 → next active cycle is M0, addr=0, we=1; cout not asserted at the old cycle 40.
- MBIST_COUNTER_CHKBOARD_EN defined, ADDR_W=2 → M0 wdata sequence 0x00, 0xFF, 0x00, 0xFF; M1 exp_data at addr 1 = 0xFF.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST sequencer.
package mbist_pkg;

    typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} march_op_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam int NUM_ELEM = 6;

    typedef struct packed {
        dir_t      dir;
        logic      two_ops;
        march_op_t op0;
        march_op_t op1;
    } elem_cfg_t;

    // March C-: M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 dn(r0,w1) M4 dn(r1,w0) M5 dn(r0)
    function automatic elem_cfg_t elem_cfg(input logic [2:0] e);
        elem_cfg_t c;
        c = '{dir: DIR_UP, two_ops: 1'b0, op0: OP_W0, op1: OP_W0};
        case (e)
            3'd1:    c = '{dir: DIR_UP,   two_ops: 1'b1, op0: OP_R0, op1: OP_W1};
            3'd2:    c = '{dir: DIR_UP,   two_ops: 1'b1, op0: OP_R1, op1: OP_W0};
            3'd3:    c = '{dir: DIR_DOWN, two_ops: 1'b1, op0: OP_R0, op1: OP_W1};
            3'd4:    c = '{dir: DIR_DOWN, two_ops: 1'b1, op0: OP_R1, op1: OP_W0};
            3'd5:    c = '{dir: DIR_DOWN, two_ops: 1'b0, op0: OP_R0, op1: OP_R0};
            default: c = '{dir: DIR_UP,   two_ops: 1'b0, op0: OP_W0, op1: OP_W0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mbist_counter_if.sv
// Controller/memory-side signal bundle of the March C- sequencer.
interface mbist_counter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              ld;
    logic              NbarT;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_data;
    logic              we;
    logic              re;
    logic [2:0]        elem;
    logic              cout;

    modport master (
        output ld, NbarT,
        input  addr, wdata, exp_data, we, re, elem, cout
    );

    modport slave (
        input  ld, NbarT,
        output addr, wdata, exp_data, we, re, elem, cout
    );
endinterface

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter with direction-aware terminal detect.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    input  dir_t              dir,
    output logic [ADDR_W-1:0] addr,
    output logic              at_terminal
);
    logic [ADDR_W-1:0] addr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= '0;
        end else if (load) begin
            addr_reg <= load_val;
        end else if (en) begin
            addr_reg <= (dir == DIR_UP) ? addr_reg + ADDR_W'(1) : addr_reg - ADDR_W'(1);
        end
    end

    assign addr        = addr_reg;
    assign at_terminal = (dir == DIR_UP) ? (&addr_reg) : ~(|addr_reg);

endmodule

// File: rtl/mbist_counter.sv
// March C- sequencer: one memory operation per cycle while NbarT is high.
// Optional checkerboard backgrounds when MBIST_COUNTER_CHKBOARD_EN is defined.
module mbist_counter
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    mbist_counter_if.slave  bus
);
    logic [2:0]        elem_reg, elem_next;
    logic              op_reg, op_next;
    elem_cfg_t         cfg, cfg_next_elem;
    march_op_t         cur_op;
    logic              active, last_op, at_term;
    logic              addr_load, addr_en;
    logic [ADDR_W-1:0] addr_load_val, addr;
    logic              is_write, bg_one;
    logic [DATA_W-1:0] pattern;

    assign cfg           = elem_cfg(elem_reg);
    assign cfg_next_elem = elem_cfg(elem_reg + 3'd1);
    assign cur_op        = op_reg ? cfg.op1 : cfg.op0;
    assign last_op       = ~cfg.two_ops | op_reg;
    assign active        = bus.NbarT & ~bus.ld & ~rst;

    mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (addr_load),
        .load_val    (addr_load_val),
        .en          (addr_en),
        .dir         (cfg.dir),
        .addr        (addr),
        .at_terminal (at_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_reg <= '0;
            op_reg   <= 1'b0;
        end else begin
            elem_reg <= elem_next;
            op_reg   <= op_next;
        end
    end

    always_comb begin
        elem_next     = elem_reg;
        op_next       = op_reg;
        addr_load     = 1'b0;
        addr_load_val = '0;
        addr_en       = 1'b0;
        if (bus.ld) begin
            elem_next = '0;
            op_next   = 1'b0;
            addr_load = 1'b1;
        end else if (active) begin
            if (!last_op) begin
                op_next = 1'b1;
            end else begin
                op_next = 1'b0;
                if (!at_term) begin
                    addr_en = 1'b1;
                end else if (elem_reg == 3'(NUM_ELEM - 1)) begin
                    elem_next = '0;
                    addr_load = 1'b1;
                end else begin
                    // New element starts at the end its direction walks away from
                    elem_next     = elem_reg + 3'd1;
                    addr_load     = 1'b1;
                    addr_load_val = (cfg_next_elem.dir == DIR_DOWN) ? '1 : '0;
                end
            end
        end
    end

    assign is_write = (cur_op == OP_W0) || (cur_op == OP_W1);
    assign bg_one   = (cur_op == OP_W1) || (cur_op == OP_R1);

`ifdef MBIST_COUNTER_CHKBOARD_EN
    assign pattern = {DATA_W{bg_one}} ^ {DATA_W{addr[0]}};
`else
    assign pattern = {DATA_W{bg_one}};
`endif

    assign bus.addr     = addr;
    assign bus.elem     = elem_reg;
    assign bus.we       = active & is_write;
    assign bus.re       = active & ~is_write;
    assign bus.wdata    = bus.we ? pattern : '0;
    assign bus.exp_data = bus.re ? pattern : '0;
    assign bus.cout     = active & last_op & (elem_reg == 3'(NUM_ELEM - 1)) & (addr == '0);

endmodule

// File: tb/tb_mbist_counter.sv
// Directed self-checking bench for mbist_counter with ADDR_W=2 (40-cycle march).
module tb_mbist_counter;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   we_cnt, re_cnt;

    always #5 clk = ~clk;

    mbist_counter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mbist_counter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // {elem, addr, we, re, cout, wdata, exp_data}
    function automatic logic [23:0] snap();
        return {bus.elem, bus.addr, bus.we, bus.re, bus.cout, bus.wdata, bus.exp_data};
    endfunction

    function automatic logic [23:0] mk(input logic [2:0] e, input logic [1:0] a, input logic w,
                                       input logic r, input logic c, input logic [7:0] wd,
                                       input logic [7:0] ed);
        return {e, a, w, r, c, wd, ed};
    endfunction

    // Expected background word for value v at address a
    function automatic logic [7:0] bg(input logic v, input logic [1:0] a);
        logic [7:0] x;
        x = {8{v}};
`ifdef MBIST_COUNTER_CHKBOARD_EN
        x = x ^ {8{a[0]}};
`endif
        return x;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] e;
        rst = 1'b1; bus.ld = 1'b0; bus.NbarT = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; bus.ld = 1'b1;
        e = mk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (snap() !== e) $display("FAIL reset_idle[%0d]: got %h expected %h", i, snap(), e);
            else begin pass_cnt++; $display("ok   reset_idle[%0d] %h", i, snap()); end
            next_cycle();
        end
        bus.ld = 1'b0;
    endtask

    task automatic test_full_run();
        logic [23:0] e;
        logic        chk;
        we_cnt = 0; re_cnt = 0;
        bus.NbarT = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.we === 1'b1) we_cnt++;
            if (bus.re === 1'b1) re_cnt++;
            total_cnt++;
            if (bus.cout !== (c == 40)) $display("FAIL cout_cycle[%0d]: got %b expected %b", c, bus.cout, (c == 40));
            else pass_cnt++;
            chk = 1'b1;
            e = '0;
            case (c)
                1, 2, 3, 4: e = mk(3'd0, 2'(c - 1), 1'b1, 1'b0, 1'b0, bg(1'b0, 2'(c - 1)), 8'h00);
                5:  e = mk(3'd1, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, bg(1'b0, 2'd0));
                6:  e = mk(3'd1, 2'd0, 1'b1, 1'b0, 1'b0, bg(1'b1, 2'd0), 8'h00);
                12: e = mk(3'd1, 2'd3, 1'b1, 1'b0, 1'b0, bg(1'b1, 2'd3), 8'h00);
                13: e = mk(3'd2, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, bg(1'b1, 2'd0));
                20: e = mk(3'd2, 2'd3, 1'b1, 1'b0, 1'b0, bg(1'b0, 2'd3), 8'h00);
                21: e = mk(3'd3, 2'd3, 1'b0, 1'b1, 1'b0, 8'h00, bg(1'b0, 2'd3));
                28: e = mk(3'd3, 2'd0, 1'b1, 1'b0, 1'b0, bg(1'b1, 2'd0), 8'h00);
                29: e = mk(3'd4, 2'd3, 1'b0, 1'b1, 1'b0, 8'h00, bg(1'b1, 2'd3));
                37: e = mk(3'd5, 2'd3, 1'b0, 1'b1, 1'b0, 8'h00, bg(1'b0, 2'd3));
                40: e = mk(3'd5, 2'd0, 1'b0, 1'b1, 1'b1, 8'h00, bg(1'b0, 2'd0));
                default: chk = 1'b0;
            endcase
            if (chk) begin
                total_cnt++;
                if (snap() !== e) $display("FAIL run_cycle[%0d]: got %h expected %h", c, snap(), e);
                else begin pass_cnt++; $display("ok   run_cycle[%0d] %h", c, snap()); end
            end
            next_cycle();
        end
        total_cnt++;
        if (we_cnt !== 20 || re_cnt !== 20)
            $display("FAIL strobe_counts: got we=%0d re=%0d expected we=20 re=20", we_cnt, re_cnt);
        else begin pass_cnt++; $display("ok   strobe_counts we=%0d re=%0d", we_cnt, re_cnt); end
        @(negedge clk);
        e = mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, bg(1'b0, 2'd0), 8'h00);
        total_cnt++;
        if (snap() !== e) $display("FAIL wrap_to_m0: got %h expected %h", snap(), e);
        else begin pass_cnt++; $display("ok   wrap_to_m0 %h", snap()); end
        bus.NbarT = 1'b0;
        next_cycle();
    endtask

    task automatic test_pause();
        logic [23:0] e;
        bus.NbarT = 1'b1;
        repeat (6) next_cycle();
        bus.NbarT = 1'b0;
        e = mk(3'd1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if (snap() !== e) $display("FAIL pause_hold[%0d]: got %h expected %h", i, snap(), e);
            else begin pass_cnt++; $display("ok   pause_hold[%0d] %h", i, snap()); end
            next_cycle();
        end
        bus.NbarT = 1'b1;
        @(negedge clk);
        e = mk(3'd1, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, bg(1'b0, 2'd1));
        total_cnt++;
        if (snap() !== e) $display("FAIL pause_resume_r0: got %h expected %h", snap(), e);
        else begin pass_cnt++; $display("ok   pause_resume_r0 %h", snap()); end
        next_cycle();
        @(negedge clk);
        e = mk(3'd1, 2'd1, 1'b1, 1'b0, 1'b0, bg(1'b1, 2'd1), 8'h00);
        total_cnt++;
        if (snap() !== e) $display("FAIL pause_resume_w1: got %h expected %h", snap(), e);
        else begin pass_cnt++; $display("ok   pause_resume_w1 %h", snap()); end
        bus.NbarT = 1'b0;
        next_cycle();
    endtask

    task automatic test_ld_abort();
        logic [23:0] e;
        bus.ld = 1'b1; bus.NbarT = 1'b0;
        next_cycle();
        bus.ld = 1'b0; bus.NbarT = 1'b1;
        repeat (16) next_cycle();
        bus.ld = 1'b1;
        @(negedge clk);
        e = mk(3'd2, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        total_cnt++;
        if (snap() !== e) $display("FAIL ld_wins_cycle17: got %h expected %h", snap(), e);
        else begin pass_cnt++; $display("ok   ld_wins_cycle17 %h", snap()); end
        next_cycle();
        bus.ld = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                e = mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, bg(1'b0, 2'd0), 8'h00);
                total_cnt++;
                if (snap() !== e) $display("FAIL ld_restart: got %h expected %h", snap(), e);
                else begin pass_cnt++; $display("ok   ld_restart %h", snap()); end
            end
            total_cnt++;
            if (bus.cout !== (c == 40)) $display("FAIL ld_cout[%0d]: got %b expected %b", c, bus.cout, (c == 40));
            else pass_cnt++;
            next_cycle();
        end
        bus.NbarT = 1'b0;
    endtask

    task automatic test_rst_abort();
        logic [23:0] e;
        bus.NbarT = 1'b1;
        repeat (10) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        e = mk(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, bg(1'b0, 2'd0), 8'h00);
        total_cnt++;
        if (snap() !== e) $display("FAIL rst_abort: got %h expected %h", snap(), e);
        else begin pass_cnt++; $display("ok   rst_abort %h", snap()); end
        bus.NbarT = 1'b0;
        next_cycle();
    endtask

`ifdef MBIST_COUNTER_CHKBOARD_EN
    task automatic test_chkboard();
        logic [7:0] wexp [4];
        wexp = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        bus.ld = 1'b1;
        next_cycle();
        bus.ld = 1'b0; bus.NbarT = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total_cnt++;
            if (bus.wdata !== wexp[c]) $display("FAIL chk_m0_wdata[%0d]: got %h expected %h", c, bus.wdata, wexp[c]);
            else begin pass_cnt++; $display("ok   chk_m0_wdata[%0d] %h", c, bus.wdata); end
            next_cycle();
        end
        repeat (2) next_cycle();
        @(negedge clk);
        total_cnt++;
        if (bus.exp_data !== 8'hFF || bus.addr !== 2'd1)
            $display("FAIL chk_m1_exp_addr1: got %h@%0d expected ff@1", bus.exp_data, bus.addr);
        else begin pass_cnt++; $display("ok   chk_m1_exp_addr1 %h", bus.exp_data); end
        bus.NbarT = 1'b0;
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_full_run();
        test_pause();
        test_ld_abort();
        test_rst_abort();
`ifdef MBIST_COUNTER_CHKBOARD_EN
        test_chkboard();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
